// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipeline stage registers.
//
// Contents:
//   occ_state_e   occupancy state of a stage register (EMPTY / ONE / FULL)
//   CTRL_WE_BIT   index of the architectural-write enable inside a control bundle
//   *_DATA_W / *_CTRL_W  payload and control widths for each stage boundary
package pipe_pkg;

  // Encoded so the state value equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  // Bit 0 of every control bundle enables the downstream architectural write.
  localparam int CTRL_WE_BIT = 0;

  // IF/ID: PC+4 and fetched instruction.
  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 2;
  // ID/EX: PC+4, two register operands and sign-extended immediate.
  localparam int IDEX_DATA_W  = 128;
  localparam int IDEX_CTRL_W  = 8;
  // EX/MEM: ALU result, store data and PC+4.
  localparam int EXMEM_DATA_W = 96;
  localparam int EXMEM_CTRL_W = 8;
  // MEM/WB: load data, ALU result and destination register.
  localparam int MEMWB_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 4;

endpackage

// File: rtl/pipe_entry.sv
// pipe_entry -- one {valid, ctrl, data} storage slot of a pipeline stage.
//
// Ports:
//   clk      rising-edge clock
//   clr_i    zero the whole entry (flush / reset); highest priority
//   ld_i     load valid_i / ctrl_i / data_i
//   inv_i    drop the valid bit only; ctrl and data keep their value
//   valid_i, ctrl_i, data_i   values written on ld_i
//   valid_o, ctrl_o, data_o   current contents
module pipe_entry #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic              inv_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr_i) begin
      // NOTE: the payload is cleared too, not just valid, because data_o must read zero after reset or flush.
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (ld_i) begin
      valid_d = valid_i;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (inv_i) begin
      // Payload is deliberately retained after the entry drains.
      valid_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    ctrl_q  <= ctrl_d;
    data_q  <= data_d;
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- parametrised pipeline stage register with valid/ready
// handshake, back-pressure, synchronous flush and bubble insertion.
//
// Build option: define PIPE_SKID_EN for a two-entry skid buffer whose
// InReady depends only on state. Without it a single head entry is used and
// InReady = !OutValid || OutReady.
//
// Ports:
//   Clk, Rst           clock, synchronous active-high reset (acts like Flush)
//   Flush              kill all held entries on the next edge
//   InValid/InReady    upstream handshake; InData/InCtrl upstream entry
//   OutValid/OutReady  downstream handshake; OutData/OutCtrl head entry
//   Occupancy          number of held entries
// OutCtrl is zero whenever OutValid is low, so a bubble never writes state.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  input  logic [CTRL_W-1:0] InCtrl,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [CTRL_W-1:0] OutCtrl,
  output logic [1:0]        Occupancy
);

  occ_state_e state_q, state_d;

  logic kill;
  logic in_xfer;
  logic out_xfer;

  logic              head_ld, head_inv;
  logic              head_valid_in;
  logic [CTRL_W-1:0] head_ctrl_in;
  logic [DATA_W-1:0] head_data_in;
  logic              head_valid;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;

  // A flushed cycle transfers nothing in either direction.
  assign kill     = Rst | Flush;
  assign in_xfer  = InValid & InReady & ~kill;
  assign out_xfer = head_valid & OutReady & ~kill;

`ifdef PIPE_SKID_EN
  logic              skid_ld, skid_inv;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              head_from_skid;

  // State-only ready: no combinational path from OutReady to InReady.
  assign InReady = (state_q != FULL);

  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    head_inv       = 1'b0;
    skid_ld        = 1'b0;
    skid_inv       = 1'b0;
    head_from_skid = 1'b0;
    if (!kill) begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            head_ld = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            head_ld = 1'b1;
          end else if (in_xfer) begin
            skid_ld = 1'b1;
            state_d = FULL;
          end else if (out_xfer) begin
            head_inv = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          // Input is never accepted here, so only the drain case exists.
          if (out_xfer) begin
            head_ld        = 1'b1;
            head_from_skid = 1'b1;
            skid_inv       = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      state_d = EMPTY;
    end
  end

  assign head_valid_in = head_from_skid ? skid_valid : 1'b1;
  assign head_ctrl_in  = head_from_skid ? skid_ctrl  : InCtrl;
  assign head_data_in  = head_from_skid ? skid_data  : InData;

  pipe_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (Clk),
    .clr_i   (kill),
    .ld_i    (skid_ld),
    .inv_i   (skid_inv),
    .valid_i (1'b1),
    .ctrl_i  (InCtrl),
    .data_i  (InData),
    .valid_o (skid_valid),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );

  assign Occupancy = state_q;
`else
  // Single entry: a full head may still accept when it drains on the same edge.
  assign InReady = ~head_valid | OutReady;

  always_comb begin
    state_d  = state_q;
    head_ld  = 1'b0;
    head_inv = 1'b0;
    if (!kill) begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            head_ld = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          // in_xfer here implies out_xfer: the old head leaves as the new one loads.
          if (in_xfer) begin
            head_ld = 1'b1;
          end else if (out_xfer) begin
            head_inv = 1'b1;
            state_d  = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      state_d = EMPTY;
    end
  end

  assign head_valid_in = 1'b1;
  assign head_ctrl_in  = InCtrl;
  assign head_data_in  = InData;

  assign Occupancy = {1'b0, head_valid};
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_head (
    .clk     (Clk),
    .clr_i   (kill),
    .ld_i    (head_ld),
    .inv_i   (head_inv),
    .valid_i (head_valid_in),
    .ctrl_i  (head_ctrl_in),
    .data_i  (head_data_in),
    .valid_o (head_valid),
    .ctrl_o  (head_ctrl),
    .data_o  (head_data)
  );

  assign OutValid = head_valid;
  assign OutData  = head_data;
  // Bubble: gate control so no downstream write happens; data is left as is.
  assign OutCtrl  = head_valid ? head_ctrl : '0;

endmodule
